ula_seq: RTL and testbench

ULA_SEQ -- requirements
Module: ula_seq

---
 rtl/ula_seq.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_ula_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq -- sequential MIPS-style ALU with iterative multiplier and an
// optional restoring divider.
//
// Single-cycle operations finish one cycle after acceptance. mult/multu use
// a radix-2 shift-add loop of WIDTH iterations. div/divu use a restoring
// loop of WIDTH iterations. Both keep the full double-width answer in the
// HI/LO registers.
//
// Build option: define ULA_SEQ_DIV_EN to include the divider. When it is not
// defined, div/divu complete in one cycle with result 0 and div_zero=1, and
// HI/LO are left unchanged.
//
// Ports:
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operation request; accepted when in_ready is also high
//   in_ready   high only while idle
//   OP         5-bit operation code
//   In1, In2   operands (rs, rt)
//   shamt      immediate shift amount
//   immediate  WIDTH/2-bit immediate for lui/ori
//   bne        Zero_flag polarity (1: flag = result != 0)
//   out_valid  one-cycle pulse when result/Zero_flag/div_zero are updated
//   result     operation result (LO for mult/div)
//   Zero_flag  zero test of result, registered together with result
//   div_zero   set when a divide had a zero divisor (or no divider is built)
// ---------------------------------------------------------------------------
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           OP,
    input  logic [WIDTH-1:0]     In1,
    input  logic [WIDTH-1:0]     In2,
    input  logic [SHW-1:0]       shamt,
    input  logic [WIDTH/2-1:0]   immediate,
    input  logic                 bne,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     result,
    output logic                 Zero_flag,
    output logic                 div_zero
);

    localparam logic [4:0] OP_SLL   = 5'b00000;
    localparam logic [4:0] OP_SRL   = 5'b00001;
    localparam logic [4:0] OP_SRA   = 5'b00010;
    localparam logic [4:0] OP_SLLV  = 5'b00011;
    localparam logic [4:0] OP_SRLV  = 5'b00100;
    localparam logic [4:0] OP_SRAV  = 5'b00101;
    localparam logic [4:0] OP_ADD   = 5'b00110;
    localparam logic [4:0] OP_SUB   = 5'b00111;
    localparam logic [4:0] OP_AND   = 5'b01000;
    localparam logic [4:0] OP_OR    = 5'b01001;
    localparam logic [4:0] OP_XOR   = 5'b01010;
    localparam logic [4:0] OP_NOR   = 5'b01011;
    localparam logic [4:0] OP_SLT   = 5'b01100;
    localparam logic [4:0] OP_SLTU  = 5'b01101;
    localparam logic [4:0] OP_LUI   = 5'b01110;
    localparam logic [4:0] OP_ORI   = 5'b01111;
    localparam logic [4:0] OP_MULT  = 5'b10000;
    localparam logic [4:0] OP_MULTU = 5'b10001;
    localparam logic [4:0] OP_DIV   = 5'b10010;
    localparam logic [4:0] OP_DIVU  = 5'b10011;
    localparam logic [4:0] OP_MFHI  = 5'b10100;
    localparam logic [4:0] OP_MFLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    // The last iteration also writes the final answer, so the loop counter
    // only needs to reach WIDTH-1.
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t                 state_reg, state_next;
    logic [WIDTH-1:0]       hi_reg, hi_next;
    logic [WIDTH-1:0]       lo_reg, lo_next;
    logic [WIDTH-1:0]       result_reg, result_next;
    logic                   zero_reg, zero_next;
    logic                   divz_reg, divz_next;
    // Shared iteration register: [2W:W] partial product / partial remainder,
    // [W-1:0] multiplier bits / dividend-then-quotient bits.
    logic [2*WIDTH:0]       work_reg, work_next;
    logic [WIDTH-1:0]       opb_reg, opb_next;      // multiplicand or divisor magnitude
    logic [SHW-1:0]         cnt_reg, cnt_next;
    logic                   neg_lo_reg, neg_lo_next; // negate product / quotient at the end
    logic                   bne_reg, bne_next;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic zflag(input logic [WIDTH-1:0] r, input logic pol);
        return pol ? (r != '0) : (r == '0);
    endfunction

    // Operand conditioning: signed ops work on magnitudes, sign fixed at the end.
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = (OP == OP_MULT) || (OP == OP_DIV);
    assign a_neg     = op_signed & In1[WIDTH-1];
    assign b_neg     = op_signed & In2[WIDTH-1];
    assign a_mag     = cond_neg(In1, a_neg);
    assign b_mag     = cond_neg(In2, b_neg);

    // One shift-add step: add multiplicand when the current multiplier bit is
    // set, then shift the whole register right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_step;
    logic [2*WIDTH-1:0] prod_fin;
    assign mul_sum  = work_reg[2*WIDTH:WIDTH] + {1'b0, (work_reg[0] ? opb_reg : '0)};
    assign mul_step = {1'b0, mul_sum, work_reg[WIDTH-1:1]};
    assign prod_fin = neg_lo_reg ? -mul_step[2*WIDTH-1:0] : mul_step[2*WIDTH-1:0];

`ifdef ULA_SEQ_DIV_EN
    logic             neg_hi_reg, neg_hi_next;   // remainder follows dividend sign
    logic [WIDTH:0]   div_shift, div_diff;
    logic [2*WIDTH:0] div_step;
    logic [WIDTH-1:0] quo_fin, rem_fin;
    // Restoring step: shift next dividend bit into the remainder and keep the
    // subtraction only if it did not go negative.
    assign div_shift = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb_reg};
    assign div_step  = div_diff[WIDTH] ? {div_shift, work_reg[WIDTH-2:0], 1'b0}
                                       : {div_diff,  work_reg[WIDTH-2:0], 1'b1};
    assign quo_fin   = cond_neg(div_step[WIDTH-1:0], neg_lo_reg);
    assign rem_fin   = cond_neg(div_step[2*WIDTH-1:WIDTH], neg_hi_reg);
`endif

    // Single-cycle result
    logic [WIDTH-1:0] alu_res;
    always_comb begin
        alu_res = '0;
        case (OP)
            OP_SLL:  alu_res = In2 << shamt;
            OP_SRL:  alu_res = In2 >> shamt;
            OP_SRA:  alu_res = $signed(In2) >>> shamt;
            OP_SLLV: alu_res = In2 << In1[SHW-1:0];
            OP_SRLV: alu_res = In2 >> In1[SHW-1:0];
            OP_SRAV: alu_res = $signed(In2) >>> In1[SHW-1:0];
            OP_ADD:  alu_res = In1 + In2;
            OP_SUB:  alu_res = In1 - In2;
            OP_AND:  alu_res = In1 & In2;
            OP_OR:   alu_res = In1 | In2;
            OP_XOR:  alu_res = In1 ^ In2;
            OP_NOR:  alu_res = ~(In1 | In2);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
            OP_LUI:  alu_res = {immediate, {(WIDTH/2){1'b0}}};
            OP_ORI:  alu_res = In1 | {{(WIDTH/2){1'b0}}, immediate};
            OP_MFHI: alu_res = hi_reg;
            OP_MFLO: alu_res = lo_reg;
            OP_MTHI: alu_res = In1;
            OP_MTLO: alu_res = In1;
            default: alu_res = '0;
        endcase
    end

    // Next-state and datapath updates
    always_comb begin
        state_next  = state_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        divz_next   = divz_reg;
        work_next   = work_reg;
        opb_next    = opb_reg;
        cnt_next    = cnt_reg;
        neg_lo_next = neg_lo_reg;
        bne_next    = bne_reg;
`ifdef ULA_SEQ_DIV_EN
        neg_hi_next = neg_hi_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    bne_next = bne;
                    cnt_next = '0;
                    case (OP)
                        OP_MULT, OP_MULTU: begin
                            work_next   = {{(WIDTH+1){1'b0}}, a_mag};
                            opb_next    = b_mag;
                            neg_lo_next = a_neg ^ b_neg;
                            state_next  = MUL;
                        end
                        OP_DIV, OP_DIVU: begin
`ifdef ULA_SEQ_DIV_EN
                            if (In2 == '0) begin
                                // Raw dividend kept so HI can return it unchanged.
                                work_next = {{(WIDTH+1){1'b0}}, In1};
                                opb_next  = '0;
                            end else begin
                                work_next = {{(WIDTH+1){1'b0}}, a_mag};
                                opb_next  = b_mag;
                            end
                            neg_lo_next = a_neg ^ b_neg;
                            neg_hi_next = a_neg;
                            state_next  = DIV;
`else
                            result_next = '0;
                            zero_next   = zflag('0, bne);
                            divz_next   = 1'b1;
                            state_next  = DONE;
`endif
                        end
                        default: begin
                            result_next = alu_res;
                            zero_next   = zflag(alu_res, bne);
                            divz_next   = 1'b0;
                            if (OP == OP_MTHI) hi_next = In1;
                            if (OP == OP_MTLO) lo_next = In1;
                            state_next  = DONE;
                        end
                    endcase
                end
            end
            MUL: begin
                if (cnt_reg == CNT_LAST) begin
                    hi_next     = prod_fin[2*WIDTH-1:WIDTH];
                    lo_next     = prod_fin[WIDTH-1:0];
                    result_next = prod_fin[WIDTH-1:0];
                    zero_next   = zflag(prod_fin[WIDTH-1:0], bne_reg);
                    divz_next   = 1'b0;
                    state_next  = DONE;
                end else begin
                    work_next = mul_step;
                    cnt_next  = cnt_reg + SHW'(1);
                end
            end
            DIV: begin
`ifdef ULA_SEQ_DIV_EN
                if (opb_reg == '0) begin
                    hi_next     = work_reg[WIDTH-1:0];
                    lo_next     = '1;
                    result_next = '1;
                    zero_next   = zflag('1, bne_reg);
                    divz_next   = 1'b1;
                    state_next  = DONE;
                end else if (cnt_reg == CNT_LAST) begin
                    hi_next     = rem_fin;
                    lo_next     = quo_fin;
                    result_next = quo_fin;
                    zero_next   = zflag(quo_fin, bne_reg);
                    divz_next   = 1'b0;
                    state_next  = DONE;
                end else begin
                    work_next = div_step;
                    cnt_next  = cnt_reg + SHW'(1);
                end
`else
                state_next = IDLE;
`endif
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            hi_reg     <= '0;
            lo_reg     <= '0;
            result_reg <= '0;
            zero_reg   <= 1'b0;
            divz_reg   <= 1'b0;
            work_reg   <= '0;
            opb_reg    <= '0;
            cnt_reg    <= '0;
            neg_lo_reg <= 1'b0;
            bne_reg    <= 1'b0;
`ifdef ULA_SEQ_DIV_EN
            neg_hi_reg <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
            divz_reg   <= divz_next;
            work_reg   <= work_next;
            opb_reg    <= opb_next;
            cnt_reg    <= cnt_next;
            neg_lo_reg <= neg_lo_next;
            bne_reg    <= bne_next;
`ifdef ULA_SEQ_DIV_EN
            neg_hi_reg <= neg_hi_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign Zero_flag = zero_reg;
    assign div_zero  = divz_reg;

endmodule

// File: tb/tb_ula_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_seq -- directed scoreboard bench for ula_seq.
// A 32-bit instance carries most of the sequence; a 16-bit instance covers
// the narrow-width cases. Expected results are queued as each request is
// driven and popped when the DUT raises out_valid. Divide expectations
// follow the ULA_SEQ_DIV_EN build option.
// ---------------------------------------------------------------------------
module tb_ula_seq;

    localparam logic [4:0] SLL = 5'd0,  SRL = 5'd1,  SRA = 5'd2,  SLLV = 5'd3;
    localparam logic [4:0] SRLV = 5'd4, SRAV = 5'd5, ADD = 5'd6,  SUB = 5'd7;
    localparam logic [4:0] NOR = 5'd11, SLT = 5'd12, SLTU = 5'd13, LUI = 5'd14;
    localparam logic [4:0] ORI = 5'd15, MULT = 5'd16, MULTU = 5'd17, DIV = 5'd18;
    localparam logic [4:0] DIVU = 5'd19, MFHI = 5'd20, MFLO = 5'd21, MTHI = 5'd22;
    localparam logic [4:0] MTLO = 5'd23, UNDEF = 5'd31;

    typedef struct {
        string       tag;
        logic [31:0] res;
        logic        zf;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        in_valid, in_ready, bne, out_valid, Zero_flag, div_zero;
    logic [4:0]  OP, shamt;
    logic [31:0] In1, In2, result;
    logic [15:0] immediate;

    // 16-bit instance
    logic        v16, rdy16, bne16, ov16, zf16, dz16;
    logic [4:0]  op16;
    logic [3:0]  sh16;
    logic [15:0] a16, b16, res16;
    logic [7:0]  imm16;

    ula_seq u0 (
        .clock(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .OP(OP), .In1(In1), .In2(In2), .shamt(shamt), .immediate(immediate), .bne(bne),
        .out_valid(out_valid), .result(result), .Zero_flag(Zero_flag), .div_zero(div_zero)
    );

    ula_seq #(.WIDTH(16)) u1 (
        .clock(clk), .reset_n(reset_n), .in_valid(v16), .in_ready(rdy16),
        .OP(op16), .In1(a16), .In2(b16), .shamt(sh16), .immediate(imm16), .bne(bne16),
        .out_valid(ov16), .result(res16), .Zero_flag(zf16), .div_zero(dz16)
    );

    // Observation mux so one wait routine serves both instances.
    logic        use16;
    wire         sel_ov  = use16 ? ov16  : out_valid;
    wire         sel_rdy = use16 ? rdy16 : in_ready;
    wire         sel_zf  = use16 ? zf16  : Zero_flag;
    wire         sel_dz  = use16 ? dz16  : div_zero;
    wire [31:0]  sel_res = use16 ? {16'h0000, res16} : result;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the first falling edge after acceptance.
    task automatic wait_out(output logic [31:0] eres);
        int   cyc;
        logic busy_bad;
        exp_t e;
        cyc = 1;
        busy_bad = 1'b0;
        while (sel_ov !== 1'b1 && cyc < 200) begin
            if (sel_rdy !== 1'b0) busy_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (sel_rdy !== 1'b0) busy_bad = 1'b1;
        eres = '0;
        chk("scoreboard_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            eres = e.res;
            chk({e.tag, ".out_valid"}, sel_ov, 1);
            chk({e.tag, ".result"}, sel_res, e.res);
            chk({e.tag, ".zero_flag"}, sel_zf, e.zf);
            chk({e.tag, ".div_zero"}, sel_dz, e.dz);
            chk({e.tag, ".latency"}, cyc, e.lat);
            chk({e.tag, ".ready_low_while_busy"}, busy_bad, 0);
            $display("op %s: result=%h zf=%b dz=%b latency=%0d", e.tag, sel_res, sel_zf, sel_dz, cyc);
        end
    endtask

    task automatic post_check(input string tag, input logic [31:0] eres);
        @(negedge clk);
        chk({tag, ".pulse_one_cycle"}, sel_ov, 0);
        chk({tag, ".result_held"}, sel_res, eres);
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [15:0] imm,
                          input logic bnev, input logic [31:0] er, input logic ez,
                          input logic edz, input int elat);
        logic [31:0] eres;
        use16 = 1'b0;
        sb.push_back('{tag, er, ez, edz, elat});
        @(negedge clk);
        chk({tag, ".ready"}, in_ready, 1);
        OP = op; In1 = a; In2 = b; shamt = sh; immediate = imm; bne = bnev; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(eres);
        post_check(tag, eres);
    endtask

    task automatic run16(input string tag, input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] sh, input logic bnev,
                         input logic [15:0] er, input logic ez, input int elat);
        logic [31:0] eres;
        use16 = 1'b1;
        sb.push_back('{tag, {16'h0000, er}, ez, 1'b0, elat});
        @(negedge clk);
        chk({tag, ".ready"}, rdy16, 1);
        op16 = op; a16 = a; b16 = b; sh16 = sh; imm16 = '0; bne16 = bnev; v16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v16 = 1'b0;
        wait_out(eres);
        post_check(tag, eres);
        use16 = 1'b0;
    endtask

    initial begin
        logic [31:0] eres;
        logic        saw_ov;
        use16 = 1'b0;
        in_valid = 1'b0; OP = '0; In1 = '0; In2 = '0; shamt = '0; immediate = '0; bne = 1'b0;
        v16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; sh16 = '0; imm16 = '0; bne16 = 1'b0;
        reset_n = 1'b1;

        // Asynchronous reset, checked before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("reset.in_ready", in_ready, 1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.result", result, 0);
        chk("reset.zero_flag", Zero_flag, 0);
        chk("reset.div_zero", div_zero, 0);
        chk("reset.in_ready16", rdy16, 1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single-cycle operations
        run_op("add_wrap", ADD, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
        run_op("sub_bne", SUB, 32'd5, 32'd5, 5'd0, 16'h0, 1'b1, 32'h0, 1'b0, 1'b0, 1);
        run_op("sll31", SLL, 32'h0, 32'h1, 5'd31, 16'h0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1);
        run_op("srl31", SRL, 32'h0, 32'h80000000, 5'd31, 16'h0, 1'b0, 32'h1, 1'b0, 1'b0, 1);
        run_op("sra4", SRA, 32'h0, 32'h80000000, 5'd4, 16'h0, 1'b0, 32'hF8000000, 1'b0, 1'b0, 1);
        run_op("sllv_lowbits", SLLV, 32'h21, 32'h3, 5'd0, 16'h0, 1'b0, 32'h6, 1'b0, 1'b0, 1);
        run_op("srlv_lowbits", SRLV, 32'hE4, 32'hF0, 5'd0, 16'h0, 1'b0, 32'hF, 1'b0, 1'b0, 1);
        run_op("srav_lowbits", SRAV, 32'h24, 32'h80000000, 5'd0, 16'h0, 1'b0, 32'hF8000000, 1'b0, 1'b0, 1);
        run_op("slt_signed", SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0, 1'b0, 32'h1, 1'b0, 1'b0, 1);
        run_op("sltu_unsigned", SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
        run_op("lui", LUI, 32'hFFFFFFFF, 32'h0, 5'd0, 16'h1234, 1'b0, 32'h12340000, 1'b0, 1'b0, 1);
        run_op("ori_zext", ORI, 32'hF0000000, 32'h0, 5'd0, 16'h8001, 1'b0, 32'hF0008001, 1'b0, 1'b0, 1);
        run_op("nor", NOR, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        run_op("undefined", UNDEF, 32'h1234, 32'h5678, 5'd3, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1);

        // Multiply
        run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'd7, 5'd0, 16'h0, 1'b0, 32'hFFFFFFEB, 1'b0, 1'b0, 33);
        run_op("mfhi_after_mult", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        run_op("mflo_after_mult", MFLO, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'hFFFFFFEB, 1'b0, 1'b0, 1);

        // multu with in_valid held high; the queued mfhi must wait for DONE.
        sb.push_back('{"multu_held", 32'hFFFFFFFE, 1'b0, 1'b0, 33});
        @(negedge clk);
        chk("multu_held.ready", in_ready, 1);
        OP = MULTU; In1 = 32'hFFFFFFFF; In2 = 32'd2; bne = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        OP = MFHI; In1 = 32'h0; In2 = 32'h0;
        wait_out(eres);
        sb.push_back('{"mfhi_after_held", 32'h1, 1'b0, 1'b0, 1});
        @(posedge clk);
        @(negedge clk);
        chk("held.no_early_accept_ov", out_valid, 0);
        chk("held.ready_after_done", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(eres);
        post_check("mfhi_after_held", eres);

        // HI/LO moves
        run_op("mthi", MTHI, 32'hA5A5A5A5, 32'h0, 5'd0, 16'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 1);
        run_op("mtlo", MTLO, 32'h5A5A5A5A, 32'h0, 5'd0, 16'h0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1);
        run_op("mfhi_moved", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 1);

        // Divide
`ifdef ULA_SEQ_DIV_EN
        run_op("div_neg", DIV, 32'hFFFFFFF9, 32'd2, 5'd0, 16'h0, 1'b0, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
        run_op("mfhi_div_neg", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1);
        run_op("divu_by_zero", DIVU, 32'd7, 32'd0, 5'd0, 16'h0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 2);
        run_op("mfhi_div0", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'h7, 1'b0, 1'b0, 1);
        run_op("div_minneg", DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, 16'h0, 1'b0, 32'h80000000, 1'b0, 1'b0, 33);
        run_op("mfhi_minneg", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 5'd0, 16'h0, 1'b0, 32'd14, 1'b0, 1'b0, 33);
        run_op("mfhi_rem", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'd2, 1'b0, 1'b0, 1);
`else
        run_op("divu_absent", DIVU, 32'd7, 32'd0, 5'd0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        run_op("div_absent", DIV, 32'hFFFFFFF9, 32'd2, 5'd0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1);
        run_op("mfhi_unchanged", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0, 1);
        run_op("mflo_unchanged", MFLO, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, 1);
`endif

        // Reset during multiply iteration 10 aborts it.
        @(negedge clk);
        chk("abort.ready", in_ready, 1);
        OP = MULT; In1 = 32'd5; In2 = 32'd6; bne = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort.ready_in_reset", in_ready, 1);
        chk("abort.ov_in_reset", out_valid, 0);
        chk("abort.result_in_reset", result, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        saw_ov = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) saw_ov = 1'b1;
        end
        chk("abort.no_out_valid", saw_ov, 0);
        $display("op abort_mult: out_valid seen=%b", saw_ov);
        run_op("mflo_after_abort", MFLO, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1);
        run_op("mfhi_after_abort", MFHI, 32'h0, 32'h0, 5'd0, 16'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1);

        // 16-bit instance
        run16("w16_sra15", SRA, 16'h8000, 16'h8000, 4'd15, 1'b0, 16'hFFFF, 1'b0, 1);
        run16("w16_sub_bne", SUB, 16'd5, 16'd5, 4'd0, 1'b1, 16'h0000, 1'b0, 1);
        run16("w16_mult", MULT, 16'hFFFD, 16'd7, 4'd0, 1'b0, 16'hFFEB, 1'b0, 17);
        run16("w16_mfhi", MFHI, 16'h0, 16'h0, 4'd0, 1'b0, 16'hFFFF, 1'b0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
